// File: rtl/cntr_rr_sched.sv
// cntr_rr_sched: round-robin scheduler sharing one modulo-CNT_MOD counter
// between N_REQ requesters. One requester is granted at a time, its burst
// length is latched, and the counter enable is driven until the burst
// completes (done) or the requester withdraws (abort).
module cntr_rr_sched #(
   parameter int N_REQ   = 4,
   parameter int CNT_W   = 4,
   parameter int CNT_MOD = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*CNT_W-1:0]     len,
   input  logic                       hold,
   output logic [N_REQ-1:0]           gnt,
   output logic                       busy,
   output logic                       cnt_en,
   output logic [CNT_W-1:0]           count,
   output logic                       done,
   output logic                       abort,
   output logic [$clog2(N_REQ)-1:0]   owner_id
);

   localparam int OW = $clog2(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE,
      S_ABORT
   } state_t;

   state_t             state_q, state_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [OW-1:0]      last_q, last_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               abort_q, abort_d;

   logic               pick_found;
   logic [OW-1:0]      pick_idx;
   logic [CNT_W-1:0]   len_arr [N_REQ];
   logic [CNT_W-1:0]   len_sel;
   logic [CNT_W-1:0]   len_clamped;

   // Unpack the per-requester length fields.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
         assign len_arr[gi] = len[gi*CNT_W +: CNT_W];
      end
   endgenerate

   // Lengths above the modulus are clamped so count never exceeds CNT_MOD-1.
   assign len_sel     = len_arr[owner_q];
   assign len_clamped = (len_sel > CNT_W'(CNT_MOD)) ? CNT_W'(CNT_MOD) : len_sel;

   // The counter only advances in RUN; hold acts in the same cycle.
   assign cnt_en = (state_q == S_RUN) && !hold;

   // Round-robin search starting one past the last served requester.
   always_comb begin
      int            idx;
      logic [OW-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      cand       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last_q) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         cand = OW'(idx);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      len_d   = len_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            count_d = '0;
            if (pick_found) begin
               owner_d = pick_idx;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            count_d = '0;
            len_d   = len_clamped;
            if (!req[owner_q]) begin
               state_d = S_ABORT;
            end else if (len_clamped == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Withdrawal wins over completion in the same cycle.
            if (!req[owner_q]) begin
               state_d = S_ABORT;
               count_d = '0;
            end else if (cnt_en) begin
               if (count_q == len_q - 1'b1) begin
                  state_d = S_DONE;
                  count_d = '0;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         S_DONE, S_ABORT: begin
            last_d  = owner_q;
            count_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase

      gnt_d = '0;
      if (state_d == S_LOAD || state_d == S_RUN) begin
         gnt_d[owner_d] = 1'b1;
      end
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      abort_d = (state_d == S_ABORT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= OW'(N_REQ - 1);
         len_q   <= '0;
         count_q <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         len_q   <= len_d;
         count_q <= count_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   assign gnt      = gnt_q;
   assign busy     = busy_q;
   assign count    = count_q;
   assign done     = done_q;
   assign abort    = abort_q;
   assign owner_id = owner_q;

endmodule

// File: tb/tb_cntr_rr_sched.sv
// Bench for cntr_rr_sched: directed bursts followed by randomized bursts,
// each cycle compared against a burst-level reference model.
module tb_cntr_rr_sched;

   localparam int N = 4;
   localparam int W = 4;
   localparam int M = 12;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] len = '0;
   logic           hold = 1'b0;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           cnt_en;
   logic [W-1:0]   count;
   logic           done;
   logic           abort;
   logic [1:0]     owner_id;

   int n_tests = 0;
   int n_fail  = 0;
   int m_last  = N - 1;

   cntr_rr_sched #(.N_REQ(N), .CNT_W(W), .CNT_MOD(M)) dut (
      .clk(clk), .rst(rst), .req(req), .len(len), .hold(hold),
      .gnt(gnt), .busy(busy), .cnt_en(cnt_en), .count(count),
      .done(done), .abort(abort), .owner_id(owner_id)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int i, input int v);
      len[i*W +: W] = W'(v);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; hold = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_count", count, 0);
      chk("rst_done", done, 0);
      chk("rst_abort", abort, 0);
      chk("rst_owner", owner_id, 0);
      m_last = N - 1;
   endtask

   // One burst from the IDLE cycle to the IDLE cycle after done/abort.
   // drop_at: count at which req is withdrawn (-2 = during LOAD, -1 none)
   // rst_at : count at which reset is applied in RUN (-1 none)
   task automatic burst(input logic [N-1:0] mask, input int exp_w, input int drop_at,
                        input int hold_at, input int hold_n, input bit rnd, input int rst_at);
      int w, l, k, hcnt, guard, en_cycles;
      bit to_abort, to_done;
      string t;
      w = -1;
      for (int j = 1; j <= N; j++) begin
         if (w < 0 && mask[(m_last + j) % N]) w = (m_last + j) % N;
      end
      req = mask;
      hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
      // LOAD
      tick();
      l = int'(len[w*W +: W]);
      if (l > M) l = M;
      if (drop_at == -2) req[w] = 1'b0;
      #1;
      chk("load_gnt", gnt, 32'(1) << w);
      chk("load_owner", owner_id, w);
      if (exp_w >= 0) chk("rr_order", owner_id, exp_w);
      chk("load_count", count, 0);
      chk("load_cnt_en", cnt_en, 0);
      chk("load_busy", busy, 1);
      to_abort = !req[w];
      to_done  = !to_abort && (l == 0);
      k = 0; hcnt = 0; guard = 0; en_cycles = 0;
      while (!to_abort && !to_done && guard < 200) begin
         guard++;
         tick();
         if (rnd) begin
            hold = ($urandom_range(0, 3) == 0);
            len  = (N*W)'($urandom);
            if ($urandom_range(0, 24) == 0) req[w] = 1'b0;
         end else begin
            hold = (k == hold_at) && (hcnt < hold_n);
            if (hold) hcnt++;
            if (k == drop_at) req[w] = 1'b0;
         end
         if (k == rst_at) rst = 1'b1;
         #1;
         chk("run_gnt", gnt, 32'(1) << w);
         chk("run_count", count, k);
         chk("run_cnt_en", cnt_en, !hold);
         chk("run_flags", {done, abort, busy}, 3'b001);
         if (rst) begin
            tick();
            rst = 1'b0; req = '0; hold = 1'b0;
            #1;
            chk("midrst_gnt", gnt, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_cnt_en", cnt_en, 0);
            chk("midrst_count", count, 0);
            chk("midrst_done_abort", {done, abort}, 0);
            chk("midrst_owner", owner_id, 0);
            m_last = N - 1;
            return;
         end
         if (!hold) en_cycles++;
         if (!req[w]) to_abort = 1'b1;
         else if (!hold) begin
            k++;
            if (k == l) to_done = 1'b1;
         end
      end
      if (guard >= 200) chk("run_bound", guard, 0);
      if (to_done) chk("en_cycles", en_cycles, l);
      // DONE or ABORT
      tick();
      req = mask & ~(N'(1) << w);
      hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      t = to_abort ? "abort" : "done";
      chk({t, "_done"}, done, to_done);
      chk({t, "_abort"}, abort, to_abort);
      chk({t, "_gnt"}, gnt, 0);
      chk({t, "_count"}, count, 0);
      chk({t, "_cnt_en"}, cnt_en, 0);
      chk({t, "_owner"}, owner_id, w);
      m_last = w;
      tick();
   endtask

   initial begin
      do_reset();
      // Single request, len 5
      set_len(0, 5);
      burst(4'b0001, 0, -1, -1, 0, 1'b0, -1);
      // Simultaneous requests from reset
      do_reset();
      for (int i = 0; i < N; i++) set_len(i, 2);
      burst(4'b0101, 0, -1, -1, 0, 1'b0, -1);
      burst(4'b0100, 2, -1, -1, 0, 1'b0, -1);
      burst(4'b1111, 3, -1, -1, 0, 1'b0, -1);
      // Round-robin fairness
      do_reset();
      for (int i = 0; i < N; i++) set_len(i, 1);
      burst(4'b1111, 0, -1, -1, 0, 1'b0, -1);
      burst(4'b1111, 1, -1, -1, 0, 1'b0, -1);
      burst(4'b1111, 2, -1, -1, 0, 1'b0, -1);
      burst(4'b1111, 3, -1, -1, 0, 1'b0, -1);
      burst(4'b1111, 0, -1, -1, 0, 1'b0, -1);
      // Hold stall at count 2 for 3 cycles
      set_len(0, 4);
      burst(4'b0001, 0, -1, 2, 3, 1'b0, -1);
      // Length corners
      set_len(0, 0);
      burst(4'b0001, 0, -1, -1, 0, 1'b0, -1);
      set_len(0, 15);
      burst(4'b0001, 0, -1, -1, 0, 1'b0, -1);
      set_len(0, 12);
      burst(4'b0001, 0, -1, -1, 0, 1'b0, -1);
      // Abort at count 3, abort during LOAD
      set_len(0, 5);
      burst(4'b0001, 0, 3, -1, 0, 1'b0, -1);
      burst(4'b0001, 0, -2, -1, 0, 1'b0, -1);
      // Reset mid-burst, next grant goes to requester 0
      set_len(2, 6);
      burst(4'b0100, 2, -1, -1, 0, 1'b0, 2);
      burst(4'b1111, 0, -1, -1, 0, 1'b0, -1);
      // Randomized bursts
      for (int r = 0; r < 60; r++) begin
         len = (N*W)'($urandom);
         burst(N'($urandom_range(1, (1 << N) - 1)), -1, -1, -1, 0, 1'b1, -1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cntr_rr_sched.md
Name: cntr_rr_sched

Overview:
Round-robin scheduler that shares one modulo-12 counter resource between N_REQ requesters.
- Each requester asks for a counting burst of a given length.
- The scheduler grants one requester at a time and loads the burst length.
- It drives the counter enable, tracks the count, and reports completion or abort.
- It sits between client blocks and the twelve-state counter datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 4, width of count and length fields
CNT_MOD, 12, counter modulus; maximum burst length

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester request level; held high until done
len  input  N_REQ*CNT_W  packed burst lengths; requester i uses bits [i*CNT_W +: CNT_W]
hold  input  1  global pause; while high, counting stalls
gnt  output  N_REQ  one-hot grant
busy  output  1  high in any state other than IDLE
cnt_en  output  1  counter advance enable to the datapath
count  output  CNT_W  current count within the burst
done  output  1  one-cycle pulse when a burst completes
abort  output  1  one-cycle pulse when a granted requester drops req early
owner_id  output  clog2(N_REQ)  index of the current or last granted requester

Behaviour:
Reset (rst=1 at a clock edge, in any state):
- state=IDLE.
- gnt=0, busy=0, cnt_en=0, count=0, done=0, abort=0, owner_id=0.
- RR pointer last=N_REQ-1, so requester 0 has top priority first.
- Reset mid-burst discards the burst silently: no done, no abort.

States: IDLE, LOAD, RUN, DONE, ABORT.

IDLE:
- If any req bit is high, select the first asserted index searching last+1, last+2, … (mod N_REQ).
- Latch the winner into owner_id and go to LOAD.
- Otherwise stay in IDLE.

LOAD (1 cycle):
- gnt[owner]=1, count=0, cnt_en=0.
- Latch L from len[owner]: if len>CNT_MOD, L=CNT_MOD (clamp); L=0 is legal.
- If req[owner]=0 → ABORT.
- Else if L=0 → DONE.
- Else → RUN.

RUN:
- gnt[owner]=1, cnt_en = ~hold.
- When cnt_en=1, count increments by 1 each cycle.
- When count==L-1 and cnt_en=1 → DONE; count does not wrap past L-1 within a burst.
- hold=1 freezes count and state; the burst timeout is unbounded.
- req[owner]=0 → ABORT. Abort takes priority over completion in the same cycle.

DONE (1 cycle):
- done=1, gnt=0, cnt_en=0, count=0.
- last=owner → IDLE.

ABORT (1 cycle):
- abort=1, gnt=0, cnt_en=0, count=0.
- last=owner → IDLE.

Timing and ordering:
- Latency with no hold: req seen in IDLE at cycle t → gnt high at t+1 … t+1+L → done at t+2+L.
- L cycles have cnt_en=1.
- Minimum inter-grant gap: 1 IDLE cycle between DONE/ABORT and the next LOAD.
- Requests arriving mid-burst wait; arbitration happens only in IDLE.
- Changes to len after LOAD are ignored.
- done and abort are never high together.

Invariants:
- gnt is one-hot or zero.
- gnt is nonzero only in LOAD or RUN.
- count ≤ CNT_MOD-1 always.
- owner_id holds its value after DONE/ABORT until the next arbitration.

Test Plan:
1. Single request:
   - Stimulus: reset, then req=0001, len0=5, hold=0 from cycle 0.
   - Response: gnt=0001 at cycles 1–6, cnt_en at 2–6 with count 0,1,2,3,4, done at 7, owner_id=0.
2. Simultaneous requests:
   - Stimulus: req=0101 held, both len=2.
   - Response: req0 is served first (done at 4); IDLE at 5; req2 is granted at 6 with owner_id=2; the next arbitration starts from index 3.
3. Round-robin fairness:
   - Stimulus: all four req high continuously, len=1.
   - Response: grants in order 0,1,2,3,0; each burst is gnt for 2 cycles, done, then IDLE.
4. Hold stall:
   - Stimulus: len=4; hold=1 while count=2 for 3 cycles.
   - Response: count stays 2 with cnt_en=0 for 3 cycles; completion is delayed 3 cycles; exactly 4 cnt_en cycles in total.
5. Length corners:
   - len=0: LOAD then DONE with no cnt_en.
   - len=15: clamped to 12; count reaches 11, then done.
   - len=12: count reaches 11, then done.
6. Abort and reset:
   - req drop at count=3: abort pulses the next cycle, no done, gnt=0, count=0.
   - rst during RUN: all outputs are 0 at the next cycle and the next grant goes to requester 0.
